// File: rtl/vga_rx_monitor_if.sv
// ---------------------------------------------------------------------------
// vga_rx_monitor_if
//   Bundles the sampled VGA pixel stream and the monitor's result outputs.
//   master : the VGA source side (drives sync/blank/RGB and the pixel strobe,
//            observes the monitor results).
//   slave  : the monitor (samples the stream, drives the results).
//
//   Stream   : clk_25MHz (pixel strobe, sampled as data), h_sync, v_sync,
//              blank_n, red_in/green_in/blue_in
//   Results  : pix_valid, pix_x, pix_y, pix_rgb, frame_done, locked,
//              err_line, err_frame, frame_count, frame_crc
// ---------------------------------------------------------------------------
interface vga_rx_monitor_if;
  logic        clk_25MHz;
  logic        h_sync;
  logic        v_sync;
  logic        blank_n;
  logic [7:0]  red_in;
  logic [7:0]  green_in;
  logic [7:0]  blue_in;

  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_done;
  logic        locked;
  logic        err_line;
  logic        err_frame;
  logic [15:0] frame_count;
  logic [15:0] frame_crc;

  modport master (
    output clk_25MHz, h_sync, v_sync, blank_n, red_in, green_in, blue_in,
    input  pix_valid, pix_x, pix_y, pix_rgb, frame_done, locked,
           err_line, err_frame, frame_count, frame_crc
  );

  modport slave (
    input  clk_25MHz, h_sync, v_sync, blank_n, red_in, green_in, blue_in,
    output pix_valid, pix_x, pix_y, pix_rgb, frame_done, locked,
           err_line, err_frame, frame_count, frame_crc
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// ---------------------------------------------------------------------------
// vga_rx_monitor
//   Sink-side monitor for a VGA pixel stream sampled in the system clock
//   domain. Recovers pixel coordinates, checks line/frame geometry, reports
//   lock, sticky error flags, a locked-frame counter and (optionally) a
//   per-frame CRC of the captured pixels.
//
//   Ports:
//     clk    : system clock, the only clock
//     reset  : synchronous, active-high
//     vga    : vga_rx_monitor_if.slave (stream in, results out)
//
//   Optional feature: define VGA_RX_CRC_EN to build the CRC-16-CCITT
//   (poly 0x1021, init 0xFFFF) over R,G,B bytes of every captured pixel.
//   Without it frame_crc is tied to 0.
// ---------------------------------------------------------------------------
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input logic             clk,
  input logic             reset,
  vga_rx_monitor_if.slave vga
);
  localparam logic [11:0] H_ACT_W = 12'(H_ACTIVE);
  localparam logic [11:0] H_TOT_W = 12'(H_TOTAL);
  localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);
  localparam logic [10:0] V_TOT_W = 11'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state_q;
  logic        s_q;
  logic        hs_act_q, hs_act_d;
  logic        vs_act_q, vs_act_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] a_cnt_q, a_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] y_q, y_d;
  logic        skip_q;
  logic        dirty_q;
  logic        pix_valid_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [23:0] pix_rgb_q;
  logic        frame_done_q, locked_q, err_line_q, err_frame_q;
  logic [15:0] frame_count_q;

  logic        tick, hs_act, vs_act, hs_edge, vs_edge;
  logic        act, pix_cap, pix_oob, line_bad, any_line_bad, frame_ok, frame_bad;
  logic [11:0] x_cur;
  logic [10:0] y_hs, v_hs, y_cur;
  logic [23:0] rgb_in;

  // Rising edge of the pixel strobe marks the one clk cycle per pixel in
  // which the stream is sampled.
  assign tick    = vga.clk_25MHz & ~s_q;
  assign hs_act  = (vga.h_sync == SYNC_ACTIVE);
  assign vs_act  = (vga.v_sync == SYNC_ACTIVE);
  assign hs_edge = tick & hs_act & ~hs_act_q;
  assign vs_edge = tick & vs_act & ~vs_act_q;
  assign rgb_in  = {vga.red_in, vga.green_in, vga.blue_in};

  // Line bookkeeping is applied before the frame check, so a coincident
  // hs/vs edge closes the last line into y and v_cnt first.
  assign y_hs  = (hs_edge && a_cnt_q != 12'd0 && y_q != 11'h7FF) ? y_q + 11'd1 : y_q;
  assign v_hs  = (hs_edge && v_cnt_q != 11'h7FF) ? v_cnt_q + 11'd1 : v_cnt_q;
  assign x_cur = hs_edge ? 12'd0 : a_cnt_q;
  assign y_cur = vs_edge ? 11'd0 : y_hs;

  assign act     = tick & vga.blank_n;
  assign pix_oob = act & ((x_cur >= H_ACT_W) | (y_cur >= V_ACT_W));
  assign pix_cap = act & ~pix_oob;

  // The first hs edge after entering ALIGN closes a line of unknown origin.
  assign line_bad = hs_edge & ~((state_q == ALIGN) & skip_q) &
                    ~((h_cnt_q == H_TOT_W) && (a_cnt_q == 12'd0 || a_cnt_q == H_ACT_W));
  assign any_line_bad = line_bad | pix_oob;
  assign frame_ok     = (v_hs == V_TOT_W) && (y_hs == V_ACT_W);
  assign frame_bad    = vs_edge & ~frame_ok;

  always_comb begin
    hs_act_d = hs_act_q;
    vs_act_d = vs_act_q;
    h_cnt_d  = h_cnt_q;
    a_cnt_d  = a_cnt_q;
    if (tick) begin
      hs_act_d = hs_act;
      vs_act_d = vs_act;
      if (hs_edge) begin
        h_cnt_d = 12'd1;
        a_cnt_d = {11'd0, vga.blank_n};
      end else begin
        if (h_cnt_q != 12'hFFF) h_cnt_d = h_cnt_q + 12'd1;
        if (vga.blank_n && a_cnt_q != 12'hFFF) a_cnt_d = a_cnt_q + 12'd1;
      end
    end
    v_cnt_d = vs_edge ? 11'd0 : v_hs;
    y_d     = vs_edge ? 11'd0 : y_hs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      s_q           <= 1'b0;
      // Treat syncs as already asserted so reset inside a sync pulse does
      // not fake an edge.
      hs_act_q      <= 1'b1;
      vs_act_q      <= 1'b1;
      h_cnt_q       <= '0;
      a_cnt_q       <= '0;
      v_cnt_q       <= '0;
      y_q           <= '0;
      skip_q        <= 1'b0;
      dirty_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      s_q          <= vga.clk_25MHz;
      hs_act_q     <= hs_act_d;
      vs_act_q     <= vs_act_d;
      h_cnt_q      <= h_cnt_d;
      a_cnt_q      <= a_cnt_d;
      v_cnt_q      <= v_cnt_d;
      y_q          <= y_d;
      frame_done_q <= vs_edge;
      pix_valid_q  <= pix_cap;
      if (pix_cap) begin
        pix_x_q   <= x_cur[9:0];
        pix_y_q   <= y_cur[9:0];
        pix_rgb_q <= rgb_in;
      end
      case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_q <= ALIGN;
            skip_q  <= 1'b1;
            dirty_q <= 1'b0;
          end
        end
        ALIGN: begin
          if (hs_edge) skip_q <= 1'b0;
          if (vs_edge) begin
            if (!dirty_q && !any_line_bad && frame_ok) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
            dirty_q <= 1'b0;
          end else if (any_line_bad) begin
            dirty_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (any_line_bad) err_line_q  <= 1'b1;
          if (frame_bad)    err_frame_q <= 1'b1;
          if (any_line_bad || frame_bad) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end else if (vs_edge) begin
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc_q, crc_acc_d, crc_seed, crc_pix, frame_crc_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // A pixel on the vs edge tick belongs to the new frame, so it is folded
  // into the freshly initialised accumulator.
  assign crc_seed  = vs_edge ? 16'hFFFF : crc_acc_q;
  assign crc_pix   = crc_byte(crc_byte(crc_byte(crc_seed, vga.red_in), vga.green_in), vga.blue_in);
  assign crc_acc_d = pix_cap ? crc_pix : crc_seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
    end else begin
      crc_acc_q <= crc_acc_d;
      if (vs_edge) frame_crc_q <= crc_acc_q;
    end
  end

  assign vga.frame_crc = frame_crc_q;
`else
  assign vga.frame_crc = 16'h0000;
`endif

  assign vga.pix_valid   = pix_valid_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.pix_rgb     = pix_rgb_q;
  assign vga.frame_done  = frame_done_q;
  assign vga.locked      = locked_q;
  assign vga.err_line    = err_line_q;
  assign vga.err_frame   = err_frame_q;
  assign vga.frame_count = frame_count_q;
endmodule
